// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF types: result-channel payload and its field widths.
package cvxif_pkg;

    localparam int unsigned X_ID_WIDTH      = 4;
    localparam int unsigned X_RFW_WIDTH     = 32;
    localparam int unsigned X_RD_WIDTH      = 5;
    localparam int unsigned X_EXCCODE_WIDTH = 6;

    // One result beat from the coprocessor toward the core.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0]      id;
        logic [X_RFW_WIDTH-1:0]     data;
        logic [X_RD_WIDTH-1:0]      rd;
        logic                       we;
        logic                       exc;
        logic [X_EXCCODE_WIDTH-1:0] exccode;
    } x_result_t;

endpackage

// File: rtl/cvxif_result_buffer.sv
// cvxif_result_buffer: in-order queue between the coprocessor result channel
// and the core writeback logic. Beats arriving while full are dropped and
// recorded in a sticky overflow flag.
//
// Ports:
//   clk_i, rst_i (async, active-high)   clock and reset
//   flush_i                             synchronous drop of all queued results
//   x_result_valid_i / x_result_i       result beat from the coprocessor
//   x_result_ready_o                    queue not full (registered state only)
//   wb_valid_o / wb_ready_i             head-entry handshake toward the core
//   wb_result_o                         head entry, read straight from storage
//   usage_o                             current occupancy
//   overflow_o                          sticky: a beat was dropped since reset
module cvxif_result_buffer
    import cvxif_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             x_result_valid_i,
    input  x_result_t        x_result_i,
    output logic             x_result_ready_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output x_result_t        wb_result_o,
    output logic [CNT_W-1:0] usage_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    x_result_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;
    logic             push;
    logic             pop;
    logic             drop;

    // Handshake outputs depend only on registered occupancy (no fall-through).
    assign x_result_ready_o = (count != CNT_W'(DEPTH));
    assign wb_valid_o       = (count != CNT_W'(0));
    assign wb_result_o      = mem[rd_ptr];
    assign usage_o          = count;
    assign overflow_o       = overflow_q;

    assign push = x_result_valid_i && x_result_ready_o && !flush_i;
    assign pop  = wb_valid_o && wb_ready_i && !flush_i;
    assign drop = x_result_valid_i && !x_result_ready_o && !flush_i;

    // Storage needs no reset; only pointer/count state is meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= x_result_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

endmodule
